// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO pop scheduler: state encoding and lane indices.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } sched_state_e;

  // Bit positions of each lane in c_req / c_valid and the internal pop vector.
  localparam int unsigned LANE0 = 0;
  localparam int unsigned LANE1 = 1;

endpackage

// File: rtl/pop_delay_line.sv
// Delays the per-lane non-flush pop strobes by the FIFO read latency so that
// c_valid lines up with data appearing on DataOut1/DataOut2.
module pop_delay_line #(
  parameter int unsigned Depth = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] stage_q [Depth];

  // Shift the pop strobes one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= 2'b00;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Sequences a dual-output FIFO feeding two MAC lanes: gates producer pushes on
// tracked occupancy, arbitrates lane pops, runs flushes and cross-checks the
// FIFO Empty/Full flags against its own count.
module fifo_pop_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned BufferSize  = 4,
  parameter int unsigned ReadLatency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 p_valid,
  output logic                 p_ready,
  output logic                 Push,
  input  logic [1:0]           c_req,
  output logic                 Pop1,
  output logic                 Pop2,
  output logic [1:0]           c_valid,
  input  logic                 Empty,
  input  logic                 Full,
  output logic [BufferWidth:0] count,
  output logic                 Round,
  output logic                 flush_done,
  output logic                 mismatch
);

  localparam int unsigned CountW = BufferWidth + 1;
  localparam logic [CountW-1:0] SizeC = CountW'(BufferSize);
  localparam logic [CountW-1:0] One   = CountW'(1);
  localparam logic [CountW-1:0] Two   = CountW'(2);

  sched_state_e      state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic              round_q, round_d;
  logic              flush_done_q, flush_done_d;
  logic              mismatch_q, mismatch_d;
  logic              push;
  logic              ready;
  logic [1:0]        pop;
  logic [1:0]        lane_pop;

  // Push gating and pop arbitration, driven from the pre-update count.
  always_comb begin
    ready   = 1'b0;
    push    = 1'b0;
    pop     = 2'b00;
    round_d = round_q;
    unique case (state_q)
      StRun: begin
        ready = (count_q < SizeC);
        push  = p_valid & ready;
        if (count_q != '0) begin
          unique case (c_req)
            2'b11: begin
              if (count_q >= Two) begin
                pop = 2'b11;
              end else begin
                // Single entry: the priority lane wins, the loser gets priority next.
                pop[round_q] = 1'b1;
                round_d      = ~round_q;
              end
            end
            2'b01:   pop[LANE0] = 1'b1;
            2'b10:   pop[LANE1] = 1'b1;
            default: pop = 2'b00;
          endcase
        end
      end
      StFlush: begin
        pop[LANE0] = (count_q >= One);
        pop[LANE1] = (count_q >= Two);
      end
      default: begin
        pop = 2'b00;
      end
    endcase
  end

  assign count_d = count_q + CountW'(push) - CountW'(pop[LANE0]) - CountW'(pop[LANE1]);

  // Next-state selection; flush wins over enable, a flush ends once the count drains.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StFlush;
        end else if (en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StFlush;
        end else if (!en) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (count_d == '0) begin
          state_d      = StIdle;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Flag consistency is sticky until reset.
  always_comb begin
    mismatch_d = mismatch_q | ((count_q == '0) != Empty) | ((count_q == SizeC) != Full);
  end

  // State, occupancy, priority and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      round_q      <= 1'b0;
      flush_done_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      round_q      <= round_d;
      flush_done_q <= flush_done_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Flush pops drain the FIFO without presenting data to the lanes.
  assign lane_pop = (state_q == StRun) ? pop : 2'b00;

  pop_delay_line #(
    .Depth(ReadLatency)
  ) u_pop_delay_line (
    .clk (clk),
    .rst (rst),
    .din (lane_pop),
    .dout(c_valid)
  );

  assign p_ready    = ready;
  assign Push       = push;
  assign Pop1       = pop[LANE0];
  assign Pop2       = pop[LANE1];
  assign count      = count_q;
  assign Round      = round_q;
  assign flush_done = flush_done_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Self-checking bench for fifo_pop_scheduler with a behavioural FIFO flag model
// and a c_valid scoreboard.
module tb_fifo_pop_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       flush;
  logic       p_valid;
  logic       p_ready;
  logic       Push;
  logic [1:0] c_req;
  logic       Pop1;
  logic       Pop2;
  logic [1:0] c_valid;
  logic       Empty;
  logic       Full;
  logic [2:0] count;
  logic       Round;
  logic       flush_done;
  logic       mismatch;

  logic [2:0] fifo_cnt;
  logic       err_inj;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] cv_q[$];
  logic [1:0] exp_cv;

  always #5 clk = ~clk;

  fifo_pop_scheduler #(
    .BufferWidth(2),
    .BufferSize (4),
    .ReadLatency(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .Push      (Push),
    .c_req     (c_req),
    .Pop1      (Pop1),
    .Pop2      (Pop2),
    .c_valid   (c_valid),
    .Empty     (Empty),
    .Full      (Full),
    .count     (count),
    .Round     (Round),
    .flush_done(flush_done),
    .mismatch  (mismatch)
  );

  // Behavioural FIFO occupancy producing the Empty/Full flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fifo_cnt <= 3'd0;
    else      fifo_cnt <= fifo_cnt + 3'(Push) - 3'(Pop1) - 3'(Pop2);
  end
  assign Empty = err_inj ? 1'b0 : (fifo_cnt == 3'd0);
  assign Full  = (fifo_cnt == 3'd4);

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; flush = 1'b0; p_valid = 1'b0; c_req = 2'b00; err_inj = 1'b0;
    #3;
    n_checks++;
    if ({count, Round, c_valid, mismatch, flush_done, p_ready, Push, Pop1, Pop2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want all zero",
               {count, Round, c_valid, mismatch, flush_done, p_ready, Push, Pop1, Pop2});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); p_valid = 1'b1; #1;
    n_checks++;
    if (p_ready !== 1'b0 || Push !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_push: got p_ready=%b Push=%b want 0 0", p_ready, Push);
    end
    @(negedge clk); p_valid = 1'b0;
  endtask

  task automatic test_fill();
    logic       exp_b;
    logic [2:0] exp_cnt;
    en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); p_valid = 1'b1; #1;
      exp_b = (i < 4);
      n_checks++;
      if (Push !== exp_b || p_ready !== exp_b) begin
        n_fail++;
        $display("FAIL fill_push[%0d]: got Push=%b p_ready=%b want %b", i, Push, p_ready, exp_b);
      end
      @(posedge clk); #1;
      exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      n_checks++;
      if (count !== exp_cnt) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, exp_cnt);
      end
    end
    @(negedge clk); p_valid = 1'b0; #1;
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_mismatch: got %b want 0", mismatch);
    end
  endtask

  task automatic test_dual_pop();
    @(negedge clk); c_req = 2'b11; #1;
    n_checks++;
    if ({Pop2, Pop1} !== 2'b11) begin
      n_fail++;
      $display("FAIL dual_pops: got %b want 11", {Pop2, Pop1});
    end
    cv_q.push_back(2'b11);
    @(posedge clk); #1;
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL dual_count: got %0d want 2", count);
    end
    exp_cv = cv_q.pop_front();
    n_checks++;
    if (c_valid !== exp_cv) begin
      n_fail++;
      $display("FAIL dual_cvalid: got %b want %b", c_valid, exp_cv);
    end
    @(negedge clk); c_req = 2'b00; #1;
    cv_q.push_back(2'b00);
    @(posedge clk); #1;
    exp_cv = cv_q.pop_front();
    n_checks++;
    if (c_valid !== exp_cv) begin
      n_fail++;
      $display("FAIL dual_cvalid_clear: got %b want %b", c_valid, exp_cv);
    end
  endtask

  task automatic test_round_robin();
    // {c_req, p_valid, expected pops, count after, Round after}
    logic [1:0] req_t   [5] = '{2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
    logic       pv_t    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] pops_t  [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [2:0] cnt_t   [5] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
    logic       round_t [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); c_req = req_t[i]; p_valid = pv_t[i]; #1;
      n_checks++;
      if ({Pop2, Pop1} !== pops_t[i]) begin
        n_fail++;
        $display("FAIL rr_pops[%0d]: got %b want %b", i, {Pop2, Pop1}, pops_t[i]);
      end
      cv_q.push_back(pops_t[i]);
      @(posedge clk); #1;
      n_checks++;
      if (count !== cnt_t[i] || Round !== round_t[i]) begin
        n_fail++;
        $display("FAIL rr_state[%0d]: got count=%0d Round=%b want count=%0d Round=%b",
                 i, count, Round, cnt_t[i], round_t[i]);
      end
      exp_cv = cv_q.pop_front();
      n_checks++;
      if (c_valid !== exp_cv) begin
        n_fail++;
        $display("FAIL rr_cvalid[%0d]: got %b want %b", i, c_valid, exp_cv);
      end
    end
  endtask

  task automatic test_push_pop();
    @(negedge clk); c_req = 2'b00; p_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL pp_prefill: got %0d want 3", count);
    end
    @(negedge clk); c_req = 2'b01; #1;
    n_checks++;
    if (Push !== 1'b1 || {Pop2, Pop1} !== 2'b01) begin
      n_fail++;
      $display("FAIL pp_strobes: got Push=%b pops=%b want 1 01", Push, {Pop2, Pop1});
    end
    cv_q.push_back(2'b01);
    @(posedge clk); #1;
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL pp_count: got %0d want 3", count);
    end
    exp_cv = cv_q.pop_front();
    n_checks++;
    if (c_valid !== exp_cv) begin
      n_fail++;
      $display("FAIL pp_cvalid: got %b want %b", c_valid, exp_cv);
    end
    @(negedge clk); c_req = 2'b00; p_valid = 1'b0;
  endtask

  task automatic test_flush();
    // {expected pops during cycle, count after, flush_done after}
    logic [1:0] pops_t [4] = '{2'b00, 2'b11, 2'b01, 2'b00};
    logic [2:0] cnt_t  [4] = '{3'd3, 3'd1, 3'd0, 3'd0};
    logic       fd_t   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      flush   = (i == 0);
      p_valid = (i != 0);
      c_req   = (i == 1 || i == 2) ? 2'b11 : 2'b00;
      #1;
      n_checks++;
      if ({Pop2, Pop1} !== pops_t[i]) begin
        n_fail++;
        $display("FAIL flush_pops[%0d]: got %b want %b", i, {Pop2, Pop1}, pops_t[i]);
      end
      if (i != 0) begin
        // Flush cycles, then the first IDLE cycle: producer must be held off.
        n_checks++;
        if (p_ready !== 1'b0 || Push !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_ready[%0d]: got p_ready=%b Push=%b want 0 0", i, p_ready, Push);
        end
      end
      cv_q.push_back(2'b00);
      @(posedge clk); #1;
      n_checks++;
      if (count !== cnt_t[i] || flush_done !== fd_t[i]) begin
        n_fail++;
        $display("FAIL flush_state[%0d]: got count=%0d flush_done=%b want count=%0d flush_done=%b",
                 i, count, flush_done, cnt_t[i], fd_t[i]);
      end
      exp_cv = cv_q.pop_front();
      n_checks++;
      if (c_valid !== exp_cv) begin
        n_fail++;
        $display("FAIL flush_cvalid[%0d]: got %b want %b", i, c_valid, exp_cv);
      end
    end
    @(negedge clk); p_valid = 1'b0; c_req = 2'b00;
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mismatch: got %b want 0", mismatch);
    end
  endtask

  task automatic test_error_reset();
    @(negedge clk); err_inj = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b want 1", mismatch);
    end
    @(negedge clk); err_inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", mismatch);
    end
    // Tie with a single entry so Round moves to lane 1 before the reset.
    @(negedge clk); p_valid = 1'b1;
    @(negedge clk); p_valid = 1'b0; c_req = 2'b11;
    @(posedge clk); #1;
    n_checks++;
    if (Round !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL err_round: got Round=%b count=%0d want 1 0", Round, count);
    end
    @(negedge clk); c_req = 2'b00; p_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); p_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #2;
    n_checks++;
    if (count !== 3'd1 || Pop1 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_midflush: got count=%0d Pop1=%b want 1 1", count, Pop1);
    end
    rst = 1'b0; #1;
    n_checks++;
    if ({count, Round, c_valid, mismatch, flush_done, p_ready, Push, Pop1, Pop2} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want all zero",
               {count, Round, c_valid, mismatch, flush_done, p_ready, Push, Pop1, Pop2});
    end
    @(negedge clk); rst = 1'b1; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_dual_pop();
    test_round_robin();
    test_push_pop();
    test_flush();
    test_error_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
